// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-aware arbiter that shares one FIFO write port among p_PORTS requesters.
// A grant is held until the requester's last beat, or until p_MAX_BEATS beats force a release.
module fifo_write_arbiter #(
  parameter int unsigned p_WIDTH     = 8,
  parameter int unsigned p_PORTS     = 4,
  parameter int unsigned p_MAX_BEATS = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [p_PORTS-1:0]           req_valid,
  input  logic [p_PORTS-1:0]           req_last,
  input  logic [p_PORTS*p_WIDTH-1:0]   req_data,
  output logic [p_PORTS-1:0]           req_ready,
  input  logic                         full,
  output logic                         wrena,
  output logic [p_WIDTH-1:0]           wrdata,
  output logic                         grant_valid,
  output logic [$clog2(p_PORTS)-1:0]   grant_id,
  output logic                         overrun
);

  localparam int unsigned ID_W  = $clog2(p_PORTS);
  localparam int unsigned CNT_W = $clog2(p_MAX_BEATS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overrun_q, overrun_d;

  logic [p_WIDTH-1:0] data_arr [p_PORTS];
  logic               sel_found;
  logic [ID_W-1:0]    sel_id;
  int unsigned        arb_idx;
  logic               g_valid;
  logic               g_last;
  logic               xfer;
  logic               at_limit;

  for (genvar i = 0; i < p_PORTS; i++) begin : g_slice
    assign data_arr[i] = req_data[i*p_WIDTH +: p_WIDTH];
  end

  // First valid requester searching upward from rr_ptr+1, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    arb_idx   = 0;
    for (int unsigned k = 1; k <= p_PORTS; k++) begin
      arb_idx = (32'(rr_ptr_q) + k) % p_PORTS;
      if (!sel_found && req_valid[ID_W'(arb_idx)]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(arb_idx);
      end
    end
  end

  assign g_valid  = req_valid[grant_id_q];
  assign g_last   = req_last[grant_id_q];
  assign xfer     = (state_q == GRANT) && g_valid && !full;
  assign at_limit = (cnt_q == CNT_W'(p_MAX_BEATS - 1));

  assign wrena       = xfer;
  assign wrdata      = data_arr[grant_id_q];
  assign req_ready   = ((state_q == GRANT) && !full) ? (p_PORTS'(1) << grant_id_q) : '0;
  assign grant_valid = (state_q == GRANT);
  assign grant_id    = grant_id_q;
  assign overrun     = overrun_q;

  // Next-state: grant in IDLE, release on last beat or at the beat limit.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    overrun_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = GRANT;
          grant_id_d = sel_id;
          cnt_d      = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (g_last || at_limit) begin
            state_d   = IDLE;
            rr_ptr_d  = grant_id_q;
            cnt_d     = '0;
            overrun_d = !g_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(p_PORTS - 1);
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: per-port beat queues drive requesters,
// expected write order is queued with the stimulus and popped on every FIFO write.
module tb_fifo_write_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned P  = 4;
  localparam int unsigned MB = 4;

  logic               clk = 1'b0;
  logic               rstn;
  logic [P-1:0]       req_valid;
  logic [P-1:0]       req_last;
  logic [P*W-1:0]     req_data;
  logic [P-1:0]       req_ready;
  logic               full;
  logic               wrena;
  logic [W-1:0]       wrdata;
  logic               grant_valid;
  logic [1:0]         grant_id;
  logic               overrun;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .p_WIDTH    (W),
    .p_PORTS    (P),
    .p_MAX_BEATS(MB)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .wrena      (wrena),
    .wrdata     (wrdata),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .overrun    (overrun)
  );

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  pq [P][$];
  logic [7:0]  exp_q [$];
  int          wr_cyc [$];
  int          cyc = 0;
  int          nwr = 0;
  int          n_ovr = 0;
  int          ov0;
  int          base;
  logic [P-1:0] acc;
  bit          hold_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic push(input int port, input logic [7:0] d, input logic last);
    pq[port].push_back({last, d});
  endtask

  task automatic exp_push(input logic [7:0] d);
    exp_q.push_back(d);
  endtask

  task automatic drive();
    for (int i = 0; i < int'(P); i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = pq[i][0][8];
        req_data[i*W +: W]   = pq[i][0][7:0];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*W +: W]   = '0;
      end
    end
  endtask

  // Observe mid-cycle: outputs reflect the state and inputs the next edge commits.
  task automatic sample();
    @(negedge clk);
    cyc++;
    acc = req_ready & req_valid;
    if (wrena) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(wrena), 32'd0);
      else check("wrdata", 32'(wrdata), 32'(exp_q.pop_front()));
      nwr++;
      wr_cyc.push_back(cyc);
    end
    if (full || !rstn) check("wrena_blocked", 32'(wrena), 32'd0);
    if (overrun) n_ovr++;
    if (hold_chk && grant_valid && grant_id == 2'd2)
      check("ready1_during_hold", 32'(req_ready[1]), 32'd0);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(P); i++)
      if (acc[i]) void'(pq[i].pop_front());
    drive();
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic run_writes(input int n, input int budget);
    int target;
    int k;
    target = nwr + n;
    k = 0;
    while (nwr < target && k < budget) begin
      tick();
      k++;
    end
    if (nwr < target) check("timeout_writes", 32'(nwr), 32'(target));
  endtask

  task automatic run_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_q.size() > 0) check("timeout_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    full      = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    acc       = '0;

    // Reset defaults with every requester valid
    for (int i = 0; i < int'(P); i++) begin
      push(i, 8'hA0 + 8'(i), 1'b1);
      exp_push(8'hA0 + 8'(i));
    end
    drive();
    repeat (3) begin
      sample();
      check("rst_wrena", 32'(wrena), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_grant_valid", 32'(grant_valid), 32'd0);
      advance();
    end
    rstn = 1'b1;
    sample();
    check("arb_latency_gv", 32'(grant_valid), 32'd0);
    advance();
    sample();
    check("first_gv", 32'(grant_valid), 32'd1);
    check("first_grant_id", 32'(grant_id), 32'd0);
    check("first_wrena", 32'(wrena), 32'd1);
    advance();
    run_drain(30);

    // Round-robin over single-beat packets
    base = wr_cyc.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < int'(P); i++) begin
        push(i, 8'h10 + 8'(i), 1'b1);
        exp_push(8'h10 + 8'(i));
      end
    drive();
    run_drain(60);
    for (int k = base + 1; k < base + 8; k++)
      check("rr_gap", 32'(wr_cyc[k] - wr_cyc[k-1]), 32'd2);

    // Packet hold: port 2 keeps the grant while ports 0 and 1 wait
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
    exp_push(8'h20); exp_push(8'h21); exp_push(8'h22);
    drive();
    tick();
    push(0, 8'h30, 1'b1); push(1, 8'h31, 1'b1);
    exp_push(8'h30); exp_push(8'h31);
    drive();
    hold_chk = 1'b1;
    base = wr_cyc.size();
    run_writes(3, 20);
    hold_chk = 1'b0;
    check("hold_gap1", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd1);
    check("hold_gap2", 32'(wr_cyc[base+2] - wr_cyc[base+1]), 32'd1);
    run_drain(30);

    // Full backpressure mid-packet; stalls must not count toward the limit
    for (int b = 0; b < 4; b++) begin
      push(3, 8'h40 + 8'(b), (b == 3));
      exp_push(8'h40 + 8'(b));
    end
    drive();
    ov0 = n_ovr;
    run_writes(1, 20);
    full = 1'b1;
    repeat (5) begin
      sample();
      check("full_ready3", 32'(req_ready[3]), 32'd0);
      check("full_gv", 32'(grant_valid), 32'd1);
      advance();
    end
    full = 1'b0;
    run_drain(30);
    check("no_overrun_after_stall", 32'(n_ovr - ov0), 32'd0);

    // Beat limit: 6-beat packet is cut after MB beats, remainder re-competes
    for (int b = 0; b < 6; b++) push(1, 8'h50 + 8'(b), (b == 5));
    push(2, 8'h60, 1'b1);
    exp_push(8'h50); exp_push(8'h51); exp_push(8'h52); exp_push(8'h53);
    exp_push(8'h60); exp_push(8'h54); exp_push(8'h55);
    drive();
    ov0 = n_ovr;
    run_writes(4, 20);
    sample();
    check("overrun_pulse", 32'(overrun), 32'd1);
    check("limit_released_gv", 32'(grant_valid), 32'd0);
    advance();
    sample();
    check("overrun_one_cycle", 32'(overrun), 32'd0);
    advance();
    run_drain(40);
    check("overrun_count", 32'(n_ovr - ov0), 32'd1);

    // Reset mid-packet aborts the grant; port 0 wins first afterwards
    for (int b = 0; b < 5; b++) push(1, 8'h70 + 8'(b), (b == 4));
    exp_push(8'h70); exp_push(8'h71);
    drive();
    run_writes(2, 20);
    push(0, 8'h80, 1'b1); push(3, 8'h83, 1'b1);
    exp_push(8'h80); exp_push(8'h72); exp_push(8'h73); exp_push(8'h74); exp_push(8'h83);
    rstn = 1'b0;
    drive();
    sample();
    check("rst_mid_wrena", 32'(wrena), 32'd0);
    check("rst_mid_gv", 32'(grant_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    advance();
    rstn = 1'b1;
    sample();
    check("rst_mid_idle", 32'(grant_valid), 32'd0);
    advance();
    sample();
    check("rst_mid_regrant_gv", 32'(grant_valid), 32'd1);
    check("rst_mid_regrant_id", 32'(grant_id), 32'd0);
    advance();
    run_drain(40);

    check("exp_empty", 32'(exp_q.size()), 32'd0);
    check("ports_empty",
          32'(pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
